uart_reg_responder: RTL and testbench

//  Byte-level command responder on the user side of the uart block: consumes received bytes
//  (rdy/dout/rdy_clr) and answers through the transmit byte port (din/wr_en/tx_busy).

---
 rtl/uart_reg_responder.sv | 182 ++++++++++++++++++
 tb/tb_uart_reg_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_responder.sv
// Byte-level command responder behind a uart: 'W' addr data writes a register,
// 'R' addr reads one back, and every command is answered with a single reply byte.
module uart_reg_responder #(
  parameter int NREGS       = 16,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic               clk_50m,
  input  logic               rst,
  input  logic               rx_rdy,
  input  logic [7:0]         rx_data,
  output logic               rx_rdy_clr,
  output logic [7:0]         tx_din,
  output logic               tx_wr_en,
  input  logic               tx_busy,
  output logic [8*NREGS-1:0] regs_flat,
  output logic               wr_strobe,
  output logic [7:0]         wr_addr,
  output logic [7:0]         err_cnt
);

  localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [8:0]      NREGS_LIM = 9'(NREGS);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BADC  = 8'h3F;
  localparam logic [7:0] RSP_BADA  = 8'h21;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    REPLY    = 3'd3,
    TX_WAIT  = 3'd4
  } state_t;

  state_t                  state_r;
  logic [NREGS-1:0][7:0]   regs_r;
  logic [ADDR_W-1:0]       addr_r;
  logic [7:0]              reply_r;
  logic                    is_write_r;
  logic                    tx_guard_r;
  logic                    rx_armed_r;
  logic [TO_W-1:0]         to_cnt_r;

  logic                    accept_s;
  logic                    in_cmd_s;
  logic                    addr_ok_s;
  logic                    to_hit_s;
  logic [7:0]              rd_data_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'h01;
  endfunction

  assign regs_flat = regs_r;

  // Byte accept qualification, address range check and timeout detect
  always_comb begin
    in_cmd_s  = 1'b0;
    accept_s  = 1'b0;
    if ((state_r == GET_ADDR) || (state_r == GET_DATA)) begin
      in_cmd_s = 1'b1;
    end else begin
      in_cmd_s = 1'b0;
    end
    // rx_armed_r also requires rdy to have dropped since the last accept, so a
    // rdy held past the clear pulse is still taken only once
    if (rx_rdy && !rx_rdy_clr && rx_armed_r && (in_cmd_s || (state_r == IDLE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    addr_ok_s = ({1'b0, rx_data} < NREGS_LIM);
    to_hit_s  = (to_cnt_r == TO_LAST);
    rd_data_s = regs_r[rx_data[ADDR_W-1:0]];
  end

  // Command FSM, register bank and all registered outputs
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_r    <= IDLE;
      regs_r     <= '0;
      addr_r     <= '0;
      reply_r    <= 8'h00;
      is_write_r <= 1'b0;
      tx_guard_r <= 1'b0;
      rx_armed_r <= 1'b1;
      to_cnt_r   <= '0;
      rx_rdy_clr <= 1'b0;
      tx_din     <= 8'h00;
      tx_wr_en   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= 8'h00;
      err_cnt    <= 8'h00;
    end else begin
      rx_rdy_clr <= accept_s;
      wr_strobe  <= 1'b0;
      tx_wr_en   <= 1'b0;

      if (accept_s) begin
        rx_armed_r <= 1'b0;
      end else if (!rx_rdy) begin
        rx_armed_r <= 1'b1;
      end

      if (accept_s || !in_cmd_s) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
              is_write_r <= (rx_data == CMD_WR);
              state_r    <= GET_ADDR;
            end else begin
              reply_r <= RSP_BADC;
              err_cnt <= sat_inc(err_cnt);
              state_r <= REPLY;
            end
          end
        end
        GET_ADDR: begin
          if (accept_s) begin
            if (!addr_ok_s) begin
              reply_r <= RSP_BADA;
              err_cnt <= sat_inc(err_cnt);
              state_r <= REPLY;
            end else if (is_write_r) begin
              addr_r  <= rx_data[ADDR_W-1:0];
              state_r <= GET_DATA;
            end else begin
              reply_r <= rd_data_s;
              state_r <= REPLY;
            end
          end else if (to_hit_s) begin
            err_cnt <= sat_inc(err_cnt);
            state_r <= IDLE;
          end
        end
        GET_DATA: begin
          if (accept_s) begin
            regs_r[addr_r] <= rx_data;
            wr_strobe      <= 1'b1;
            wr_addr        <= 8'(addr_r);
            reply_r        <= RSP_OK;
            state_r        <= REPLY;
          end else if (to_hit_s) begin
            err_cnt <= sat_inc(err_cnt);
            state_r <= IDLE;
          end
        end
        REPLY: begin
          if (!tx_busy) begin
            tx_din     <= reply_r;
            tx_wr_en   <= 1'b1;
            tx_guard_r <= 1'b1;
            state_r    <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // the uart raises tx_busy only after seeing wr_en, so skip one cycle
          if (tx_guard_r) begin
            tx_guard_r <= 1'b0;
          end else if (!tx_busy) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: a small uart model answers rdy_clr and
// produces tx_busy after each wr_en; expectations are hand-computed per step.
module tb_uart_reg_responder;

  localparam int NREGS = 16;
  localparam int TO    = 100;

  logic               clk_50m = 1'b0;
  logic               rst;
  logic               rx_rdy;
  logic [7:0]         rx_data;
  logic               rx_rdy_clr;
  logic [7:0]         tx_din;
  logic               tx_wr_en;
  logic               tx_busy;
  logic [8*NREGS-1:0] regs_flat;
  logic               wr_strobe;
  logic [7:0]         wr_addr;
  logic [7:0]         err_cnt;

  logic               force_busy;
  int                 busy_cnt = 0;
  int                 clr_cnt  = 0;
  int                 wr_cnt   = 0;
  int                 ws_cnt   = 0;
  int                 n_assert = 0;
  int                 n_fail   = 0;
  logic [8*NREGS-1:0] exp_regs;

  uart_reg_responder #(.NREGS(NREGS), .TIMEOUT_CYC(TO)) dut (
    .clk_50m    (clk_50m),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .rx_rdy_clr (rx_rdy_clr),
    .tx_din     (tx_din),
    .tx_wr_en   (tx_wr_en),
    .tx_busy    (tx_busy),
    .regs_flat  (regs_flat),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .err_cnt    (err_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  assign tx_busy = force_busy || (busy_cnt != 0);

  // pulse counters and the uart transmitter busy model
  always @(posedge clk_50m) begin
    if (rx_rdy_clr) clr_cnt <= clr_cnt + 1;
    if (wr_strobe)  ws_cnt  <= ws_cnt + 1;
    if (tx_wr_en) begin
      wr_cnt   <= wr_cnt + 1;
      busy_cnt <= 8;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got     = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_50m);
      if (rx_rdy_clr) begin
        got = 1'b1;
        break;
      end
    end
    rx_rdy = 1'b0;
    chk("rx_accept", {127'd0, got}, 128'd1);
    @(negedge clk_50m);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp_b, output int cyc);
    logic       found;
    logic [7:0] d;
    found = 1'b0;
    d     = 8'h00;
    cyc   = 0;
    while (cyc < 3000) begin
      if (tx_wr_en) begin
        found = 1'b1;
        d     = tx_din;
        break;
      end
      @(negedge clk_50m);
      cyc = cyc + 1;
    end
    chk({tag, "_seen"}, {127'd0, found}, 128'd1);
    chk({tag, "_byte"}, {120'd0, d}, {120'd0, exp_b});
    repeat (14) @(negedge clk_50m);
  endtask

  initial begin
    int w0, c0, s0, cyc;
    rst        = 1'b1;
    rx_rdy     = 1'b0;
    rx_data    = 8'h00;
    force_busy = 1'b0;
    exp_regs   = '0;
    repeat (3) @(negedge clk_50m);
    chk("rst_regs",    regs_flat, 128'd0);
    chk("rst_wr_en",   {127'd0, tx_wr_en}, 128'd0);
    chk("rst_rdy_clr", {127'd0, rx_rdy_clr}, 128'd0);
    chk("rst_err",     {120'd0, err_cnt}, 128'd0);
    chk("rst_din",     {120'd0, tx_din}, 128'd0);
    chk("rst_wr_addr", {120'd0, wr_addr}, 128'd0);
    rst = 1'b0;
    @(negedge clk_50m);

    // write reg 3 = A5, reply 'K' two cycles after the last accept
    w0 = wr_cnt; s0 = ws_cnt;
    send_byte(8'h57);
    send_byte(8'h03);
    send_byte(8'hA5);
    wait_tx("wr_reply", 8'h4B, cyc);
    chk("wr_latency", 128'(cyc), 128'd0);
    exp_regs[8*3 +: 8] = 8'hA5;
    chk("wr_regs",    regs_flat, exp_regs);
    chk("wr_strobes", 128'(ws_cnt - s0), 128'd1);
    chk("wr_addr",    {120'd0, wr_addr}, 128'd3);
    chk("wr_pulses",  128'(wr_cnt - w0), 128'd1);

    // read reg 3 back
    w0 = wr_cnt; s0 = ws_cnt;
    send_byte(8'h52);
    send_byte(8'h03);
    wait_tx("rd_reply", 8'hA5, cyc);
    chk("rd_pulses",  128'(wr_cnt - w0), 128'd1);
    chk("rd_regs",    regs_flat, exp_regs);
    chk("rd_no_wr",   128'(ws_cnt - s0), 128'd0);

    // unknown command, then out-of-range address
    send_byte(8'h41);
    wait_tx("badcmd", 8'h3F, cyc);
    chk("badcmd_err", {120'd0, err_cnt}, 128'd1);
    s0 = ws_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    wait_tx("badaddr", 8'h21, cyc);
    chk("badaddr_err", {120'd0, err_cnt}, 128'd2);
    chk("badaddr_nowr", 128'(ws_cnt - s0), 128'd0);
    chk("badaddr_regs", regs_flat, exp_regs);

    // timeout after the first byte
    w0 = wr_cnt;
    send_byte(8'h57);
    repeat (50) @(negedge clk_50m);
    chk("to_early_err", {120'd0, err_cnt}, 128'd2);
    repeat (60) @(negedge clk_50m);
    chk("to_err",       {120'd0, err_cnt}, 128'd3);
    chk("to_no_tx",     128'(wr_cnt - w0), 128'd0);
    send_byte(8'h52);
    send_byte(8'h00);
    wait_tx("to_next", 8'h00, cyc);

    // reply held off by tx_busy while the next command byte waits
    force_busy = 1'b1;
    send_byte(8'h52);
    send_byte(8'h03);
    w0 = wr_cnt; c0 = clr_cnt;
    rx_data = 8'h52;
    rx_rdy  = 1'b1;
    repeat (500) @(negedge clk_50m);
    chk("busy_no_tx",  128'(wr_cnt - w0), 128'd0);
    chk("busy_no_clr", 128'(clr_cnt - c0), 128'd0);
    force_busy = 1'b0;
    for (int i = 0; i < 50 && !tx_wr_en; i++) @(negedge clk_50m);
    chk("busy_clr_at_tx", 128'(clr_cnt - c0), 128'd0);
    wait_tx("busy_reply", 8'hA5, cyc);
    chk("busy_consumed", 128'(clr_cnt - c0), 128'd1);
    rx_rdy = 1'b0;
    @(negedge clk_50m);
    send_byte(8'h03);
    wait_tx("busy_next", 8'hA5, cyc);

    // rdy held 3 cycles is one byte: 'W' then addr 5, data 3C
    c0 = clr_cnt;
    rx_data = 8'h57;
    rx_rdy  = 1'b1;
    repeat (3) @(negedge clk_50m);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk_50m);
    chk("hold_one_clr", 128'(clr_cnt - c0), 128'd1);
    send_byte(8'h05);
    send_byte(8'h3C);
    wait_tx("hold_reply", 8'h4B, cyc);
    exp_regs[8*5 +: 8] = 8'h3C;
    chk("hold_regs", regs_flat, exp_regs);

    // reset in GET_DATA
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h07);
    rst = 1'b1;
    repeat (2) @(negedge clk_50m);
    chk("mid_rst_regs",  regs_flat, 128'd0);
    chk("mid_rst_err",   {120'd0, err_cnt}, 128'd0);
    chk("mid_rst_wr_en", {127'd0, tx_wr_en}, 128'd0);
    chk("mid_rst_strb",  {127'd0, wr_strobe}, 128'd0);
    rst = 1'b0;
    @(negedge clk_50m);
    chk("mid_rst_no_tx", 128'(wr_cnt - w0), 128'd0);
    send_byte(8'h52);
    send_byte(8'h00);
    wait_tx("post_rst", 8'h00, cyc);
    send_byte(8'h52);
    send_byte(8'h07);
    wait_tx("post_rst_r7", 8'h00, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
